// File: rtl/cp0_coprocessor_if.sv
// Bus between the M stage and Coprocessor 0: mtc0/mfc0 access, victim info,
// interrupt lines and the flush request returned to the pipeline.
interface cp0_coprocessor_if;
  logic        en;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0In;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;

  modport master (
    output en, CP0Addr, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  CP0Out, EPCOut, Req
  );

  modport slave (
    input  en, CP0Addr, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output CP0Out, EPCOut, Req
  );
endinterface

// File: rtl/cp0_coprocessor.sv
// Coprocessor 0: SR/Cause/EPC storage and the per-cycle interrupt/exception
// decision for the instruction in the M stage.
module cp0_coprocessor (
  input  logic                 clk,
  input  logic                 reset,
  cp0_coprocessor_if.slave     bus
);
  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  // Interrupts look at the live lines, not IP, so they are seen in the same cycle.
  assign w_int_req = (|(bus.HWInt & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (bus.ExcCodeIn != 5'd0) & ~r_exl;
  assign w_req     = (w_int_req | w_exc_req) & ~reset;

  assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exc, 2'd0};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im  <= '0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_bd  <= 1'b0;
      r_ip  <= '0;
      r_exc <= '0;
      r_epc <= '0;
    end else begin
      r_ip <= bus.HWInt;
      if (w_req) begin
        r_exl <= 1'b1;
        r_bd  <= bus.BDIn;
        r_exc <= w_int_req ? 5'd0 : bus.ExcCodeIn;
        r_epc <= bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
      end else begin
        if (bus.en && bus.CP0Addr == ADDR_SR) begin
          r_im  <= bus.CP0In[15:10];
          r_exl <= bus.CP0In[1];
          r_ie  <= bus.CP0In[0];
        end
        if (bus.en && bus.CP0Addr == ADDR_EPC)
          r_epc <= bus.CP0In;
        // Placed after the SR write so eret wins over a simultaneous mtc0 SR.
        if (bus.EXLClr)
          r_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.CP0Out = 32'd0;
    if (!reset) begin
      case (bus.CP0Addr)
        ADDR_SR:    bus.CP0Out = w_sr;
        ADDR_CAUSE: bus.CP0Out = w_cause;
        ADDR_EPC:   bus.CP0Out = r_epc;
        default:    bus.CP0Out = 32'd0;
      endcase
    end
  end

  assign bus.EPCOut = reset ? 32'd0 : r_epc;
  assign bus.Req    = w_req;
endmodule
